// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared constants and FSM encoding for the instruction fetch queue.
//   XLEN_DEF  default address/data width
//   ILEN      instruction word width
//   PC_INC    fetch address step per request
//   fq_state_e RUN / DRAIN state encoding
package fetch_queue_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned ILEN     = 32;
  localparam int unsigned PC_INC   = 4;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fq_state_e;

  // Bits needed to hold a count of 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the instruction-memory, redirect and decode-side
// handshakes of the fetch queue.
//   master : fetch queue side (drives imem_req_*, out_*)
//   slave  : environment side (memory, branch unit, decode)
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN = fetch_queue_pkg::XLEN_DEF
) ();

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_insn;
  logic            out_ready;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_insn,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_insn,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fq_fifo.sv
// fq_fifo: synchronous FIFO with flush, used as the fetch queue storage.
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : empty the FIFO on this edge (overrides push/pop)
//   push_i/din_i : write request and data (ignored when full, unless popping)
//   pop_i        : read request (ignored when empty)
//   dout_o       : head entry
//   empty_o      : no entries held
//   count_o      : number of entries held
module fq_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_c;
  logic             do_push_c;
  logic             do_pop_c;

  assign empty_o = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A simultaneous pop frees the slot, so a full FIFO may still accept a push.
  assign do_pop_c  = pop_i && !empty_o && !flush_i;
  assign do_push_c = push_i && !flush_i && (!full_c || do_pop_c);

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  // Control state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push_c) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit issuing sequential word fetches to an
// in-order instruction memory and buffering the returned words for decode.
// Redirects flush the buffer, restart fetching at the new PC and discard the
// responses of every request still in flight.
//   CLK    : clock
//   reset  : synchronous active-high reset
//   bus    : fetch_queue_if.master (imem request/response, redirect, decode output)
// Optional build macro FETCH_QUEUE_BYPASS_EN: a fresh response arriving while
// the queue is empty is presented to decode in the same cycle, and is not
// stored when decode takes it.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned    XLEN      = XLEN_DEF,
  parameter int unsigned    DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input logic          CLK,
  input logic          reset,
  fetch_queue_if.master bus
);

  localparam int unsigned     CW         = cnt_width(DEPTH);
  localparam int unsigned     EW         = XLEN + ILEN;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fq_state_e       state_q, state_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0] rsp_addr_q, rsp_addr_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   stale_q, stale_d;

  logic [CW-1:0]   occ;
  logic            fifo_empty;
  logic [EW-1:0]   fifo_dout;
  logic            push_c, pop_c, flush_c;

  logic [CW:0]     inflight_c;
  logic            req_valid_c, req_fire_c;
  logic            rsp_take_c, fresh_c;
  logic [XLEN-1:0] redir_addr_c;

  logic            out_valid_c;
  logic [XLEN-1:0] out_pc_c;
  logic [ILEN-1:0] out_insn_c;

  // Buffered entries are {pc, insn}.
  fq_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (reset),
    .flush_i (flush_c),
    .push_i  (push_c),
    .din_i   ({rsp_addr_q, bus.imem_rsp_data}),
    .pop_i   (pop_c),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (occ)
  );

  // Issue only while every buffered or in-flight word has a guaranteed slot.
  assign inflight_c   = {1'b0, occ} + {1'b0, outst_q};
  assign req_valid_c  = !reset && !bus.redirect_valid && (inflight_c < (CW+1)'(DEPTH));
  assign req_fire_c   = req_valid_c && bus.imem_req_ready;
  assign rsp_take_c   = bus.imem_rsp_valid && (outst_q != '0);
  // A response is kept only outside DRAIN and outside a redirect cycle.
  assign fresh_c      = rsp_take_c && !bus.redirect_valid && (state_q == ST_RUN);
  assign redir_addr_c = bus.redirect_pc & ALIGN_MASK;

  // Next-state: FSM, fetch/response address tracking, in-flight accounting.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    rsp_addr_d   = rsp_addr_q;
    stale_d      = stale_q;
    push_c       = 1'b0;
    pop_c        = 1'b0;
    flush_c      = 1'b0;
    outst_d      = outst_q + CW'(req_fire_c) - CW'(rsp_take_c);

    if (bus.redirect_valid) begin
      // Everything still in flight after this edge belongs to the old path.
      flush_c      = 1'b1;
      fetch_addr_d = redir_addr_c;
      rsp_addr_d   = redir_addr_c;
      stale_d      = outst_d;
    end else begin
      if (req_fire_c) fetch_addr_d = fetch_addr_q + XLEN'(PC_INC);
      if (rsp_take_c && (state_q == ST_DRAIN)) stale_d = stale_q - CW'(1);
      if (fresh_c) begin
        rsp_addr_d = rsp_addr_q + XLEN'(PC_INC);
        push_c     = 1'b1;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (fifo_empty && bus.out_ready) push_c = 1'b0;
`endif
      end
      pop_c = !fifo_empty && bus.out_ready;
    end

    case (state_q)
      ST_RUN:   if (stale_d != '0) state_d = ST_DRAIN;
      ST_DRAIN: if (stale_d == '0) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Decode-side outputs; pc/insn read as zero whenever nothing is offered.
  always_comb begin
    out_valid_c = !reset && !fifo_empty;
    out_pc_c    = '0;
    out_insn_c  = '0;
    if (out_valid_c) begin
      out_pc_c   = fifo_dout[EW-1:ILEN];
      out_insn_c = fifo_dout[ILEN-1:0];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (!reset && fifo_empty && fresh_c) begin
      out_valid_c = 1'b1;
      out_pc_c    = rsp_addr_q;
      out_insn_c  = bus.imem_rsp_data;
    end
`endif
  end

  assign bus.imem_req_valid = req_valid_c;
  assign bus.imem_req_addr  = fetch_addr_q;
  assign bus.out_valid      = out_valid_c;
  assign bus.out_pc         = out_pc_c;
  assign bus.out_insn       = out_insn_c;

  // State registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= ST_RUN;
      fetch_addr_q <= RESET_VEC;
      rsp_addr_q   <= RESET_VEC;
      outst_q      <= '0;
      stale_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      rsp_addr_q   <= rsp_addr_d;
      outst_q      <= outst_d;
      stale_q      <= stale_d;
    end
  end

endmodule
